// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the Arith issue stage: opcode set, issue FSM states and
// opcode classification helpers.
package alu_issue_ctrl_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ALU_OP_W   = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_OP_ADD = 4'd0,
        ALU_OP_SUB = 4'd1,
        ALU_OP_INC = 4'd2,
        ALU_OP_DEC = 4'd3,
        ALU_OP_MUL = 4'd4,
        ALU_OP_DIV = 4'd5,
        ALU_OP_SHL = 4'd6,
        ALU_OP_SHR = 4'd7
    } enum_alu_opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } enum_issue_state_t;

    // Opcodes whose completion rewrites the persistent carry flag.
    function automatic logic is_carry_op(input enum_alu_opcode_t op);
        case (op)
            ALU_OP_ADD, ALU_OP_SUB, ALU_OP_INC, ALU_OP_DEC,
            ALU_OP_SHL, ALU_OP_SHR: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Opcodes that Arith actually implements; anything else yields a zero result.
    function automatic logic is_arith_op(input enum_alu_opcode_t op);
        case (op)
            ALU_OP_ADD, ALU_OP_SUB, ALU_OP_INC, ALU_OP_DEC,
            ALU_OP_MUL, ALU_OP_DIV, ALU_OP_SHL, ALU_OP_SHR: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue/response control in front of Arith: registers operands, captures the
// result one cycle later, keeps a chained carry flag and counts completions.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = alu_issue_ctrl_pkg::DATA_WIDTH,
    parameter int unsigned CNT_W      = 16,
    parameter logic        CARRY_RST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  enum_alu_opcode_t      req_op,
    input  logic                  req_use_carry,
    input  logic                  clear_carry,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic                  alu_cin,
    output enum_alu_opcode_t      alu_op,
    input  logic [DATA_WIDTH-1:0] alu_res,
    input  logic [1:0]            alu_flag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_carry,
    output logic                  rsp_zero,
    output logic                  rsp_err,
    output logic                  carry_q,
    output logic [CNT_W-1:0]      op_count
);

    enum_issue_state_t     state;
    logic [DATA_WIDTH-1:0] cap_data;
    logic                  cap_zero;
    logic                  cap_err;
    logic                  cap_carry;
    logic                  flag_unused;

    // Arith's zero flag is redundant with our own result compare.
    assign flag_unused = alu_flag[1];

    // A new request may enter only when no response is left unaccepted.
    assign req_ready = (state == IDLE) || ((state == HOLD) && rsp_ready);

    // Result and carry as they will be captured at the end of EXEC.
    always_comb begin
        cap_data  = alu_res;
        cap_zero  = (alu_res == '0);
        cap_err   = 1'b0;
        cap_carry = carry_q;
        if (!is_arith_op(alu_op)) begin
            cap_data = '0;
            cap_zero = 1'b1;
        end else if ((alu_op == ALU_OP_DIV) && (alu_b == '0)) begin
            cap_data = '0;
            cap_zero = 1'b0;
            cap_err  = 1'b1;
        end else if (is_carry_op(alu_op)) begin
            case (alu_op)
                ALU_OP_SHL: cap_carry = alu_a[DATA_WIDTH-1];
                ALU_OP_SHR: cap_carry = alu_a[0];
                default:    cap_carry = alu_flag[0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cin   <= 1'b0;
            alu_op    <= ALU_OP_ADD;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            carry_q   <= CARRY_RST;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_carry) begin
                        carry_q <= CARRY_RST;
                    end
                    if (req_valid) begin
                        alu_a   <= req_a;
                        alu_b   <= req_b;
                        alu_op  <= req_op;
                        alu_cin <= req_use_carry & carry_q;
                        state   <= EXEC;
                    end
                end
                // Capture always overrides a concurrent clear_carry.
                EXEC: begin
                    rsp_data  <= cap_data;
                    rsp_zero  <= cap_zero;
                    rsp_err   <= cap_err;
                    rsp_carry <= cap_carry;
                    carry_q   <= cap_carry;
                    rsp_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (clear_carry) begin
                        carry_q <= CARRY_RST;
                    end
                    if (rsp_ready) begin
                        op_count  <= op_count + CNT_W'(1);
                        rsp_valid <= 1'b0;
                        if (req_valid) begin
                            alu_a   <= req_a;
                            alu_b   <= req_b;
                            alu_op  <= req_op;
                            alu_cin <= req_use_carry & carry_q;
                            state   <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with an Arith stand-in, directed
// vectors, corner-case sequences and a randomized run against a reference model.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_a;
    logic [7:0]       req_b;
    enum_alu_opcode_t req_op;
    logic             req_use_carry;
    logic             clear_carry;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic             alu_cin;
    enum_alu_opcode_t alu_op;
    logic [7:0]       alu_res;
    logic [1:0]       alu_flag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_data;
    logic             rsp_carry;
    logic             rsp_zero;
    logic             rsp_err;
    logic             carry_q;
    logic [CNT_W-1:0] op_count;

    int passed = 0;
    int total  = 0;

    int   m_count = 0;
    logic m_carry = 1'b0;
    int   e_d;
    bit   e_c, e_z, e_e;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .req_use_carry(req_use_carry), .clear_carry(clear_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_res(alu_res), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_err(rsp_err), .carry_q(carry_q), .op_count(op_count)
    );

    // Arith stand-in; garbage on undefined cases so the controller must mask it.
    logic [8:0] t;
    always_comb begin
        t        = '0;
        alu_res  = '0;
        alu_flag = '0;
        case (alu_op)
            ALU_OP_ADD: begin t = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_cin}; alu_res = t[7:0]; alu_flag[0] = t[8]; end
            ALU_OP_SUB: begin t = {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, alu_cin}; alu_res = t[7:0]; alu_flag[0] = t[8]; end
            ALU_OP_INC: begin t = {1'b0, alu_a} + 9'd1; alu_res = t[7:0]; alu_flag[0] = t[8]; end
            ALU_OP_DEC: begin t = {1'b0, alu_a} - 9'd1; alu_res = t[7:0]; alu_flag[0] = t[8]; end
            ALU_OP_MUL: begin alu_res = alu_a * alu_b; alu_flag[0] = 1'b1; end
            ALU_OP_DIV: begin alu_res = (alu_b == 8'd0) ? 8'hFF : alu_a / alu_b; alu_flag[0] = 1'b1; end
            ALU_OP_SHL: begin alu_res = {alu_a[6:0], alu_cin}; alu_flag[0] = alu_a[7]; end
            ALU_OP_SHR: begin alu_res = {alu_cin, alu_a[7:1]}; alu_flag[0] = alu_a[0]; end
            default:    begin alu_res = 8'hA5; alu_flag = 2'b11; end
        endcase
        alu_flag[1] = (alu_res == 8'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // Reference behaviour from arithmetic definitions.
    function automatic void ref_op(input int op, input int a, input int b, input int cin,
                                   output int d, output bit upd, output bit c,
                                   output bit z, output bit e);
        upd = 0; c = 0; e = 0; d = 0;
        case (op)
            0: begin d = a + b + cin; c = (d > 255); d = d % 256; upd = 1; end
            1: begin d = a - b - cin; c = (d < 0); d = (d + 512) % 256; upd = 1; end
            2: begin d = (a + 1) % 256; c = (a == 255); upd = 1; end
            3: begin d = (a + 255) % 256; c = (a == 0); upd = 1; end
            4: d = (a * b) % 256;
            5: if (b == 0) e = 1; else d = a / b;
            6: begin d = (a * 2 + cin) % 256; c = (a >= 128); upd = 1; end
            7: begin d = a / 2 + cin * 128; c = (a % 2 == 1); upd = 1; end
            default: d = 0;
        endcase
        z = (d == 0) && !e;
    endfunction

    // One transaction from IDLE through to a held response (not accepted).
    task automatic send(input string nm, input enum_alu_opcode_t op, input logic [7:0] a,
                        input logic [7:0] b, input logic uc, input logic clr_exec,
                        input logic exp_cin, input int xd, input bit xc, input bit xz, input bit xe);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_use_carry = uc;
        #1 chk({nm, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; clear_carry = clr_exec;
        chk({nm, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, "_alu_a"}, 32'(alu_a), 32'(a));
        chk({nm, "_alu_b"}, 32'(alu_b), 32'(b));
        chk({nm, "_alu_op"}, 32'(alu_op), 32'(op));
        chk({nm, "_alu_cin"}, 32'(alu_cin), 32'(exp_cin));
        @(posedge clk); #1;
        clear_carry = 1'b0;
        chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, "_rsp_data"}, 32'(rsp_data), 32'(xd));
        chk({nm, "_rsp_carry"}, 32'(rsp_carry), 32'(xc));
        chk({nm, "_rsp_zero"}, 32'(rsp_zero), 32'(xz));
        chk({nm, "_rsp_err"}, 32'(rsp_err), 32'(xe));
        chk({nm, "_carry_q"}, 32'(carry_q), 32'(xc));
        e_d = xd; e_c = xc; e_z = xz; e_e = xe; m_carry = xc;
    endtask

    task automatic send_ref(input string nm, input enum_alu_opcode_t op, input logic [7:0] a,
                            input logic [7:0] b, input logic uc, input logic clr_exec);
        int d; bit upd, c, z, e; logic cin;
        cin = uc & m_carry;
        ref_op(int'(op), int'(a), int'(b), int'(cin), d, upd, c, z, e);
        send(nm, op, a, b, uc, clr_exec, cin, d, upd ? c : m_carry, z, e);
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        m_count++;
    endtask

    typedef struct {
        enum_alu_opcode_t op;
        logic [7:0] a, b;
        logic uc;
        logic [7:0] d;
        logic c, z, e, cin;
    } vec_t;

    initial begin
        vec_t vt[13];
        int   ph;
        logic t_cin, t_c, t_z, t_e;
        logic [7:0] t_a;
        enum_alu_opcode_t t_op;
        int   t_d;

        vt[0]  = '{ALU_OP_ADD, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{ALU_OP_ADD, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[2]  = '{ALU_OP_DIV, 8'd9,  8'd0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{ALU_OP_DIV, 8'd9,  8'd3,  1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{ALU_OP_SHL, 8'h81, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{ALU_OP_SHR, 8'h02, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{ALU_OP_SUB, 8'd5,  8'd5,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{ALU_OP_INC, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{ALU_OP_MUL, 8'h10, 8'h10, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{ALU_OP_SUB, 8'h00, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[10] = '{enum_alu_opcode_t'(4'd12), 8'h03, 8'h04, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[11] = '{ALU_OP_DEC, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[12] = '{ALU_OP_SHR, 8'h01, 8'h00, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = ALU_OP_ADD;
        req_use_carry = 1'b0; clear_carry = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_flags", 32'({rsp_carry, rsp_zero, rsp_err}), 32'd0);
        chk("rst_alu_ab", 32'({alu_a, alu_b, alu_cin}), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'(ALU_OP_ADD));
        chk("rst_carry_q", 32'(carry_q), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Directed vectors; carry chains from one to the next.
        for (int i = 0; i < 13; i++) begin
            send($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].uc, 1'b0,
                 vt[i].cin, int'(vt[i].d), vt[i].c, vt[i].z, vt[i].e);
            accept();
        end
        chk("vec_op_count", 32'(op_count), 32'd13);

        // Backpressure: response held while a new request waits.
        send_ref("bp0", ALU_OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_op = ALU_OP_ADD; req_a = 8'h33; req_b = 8'h11; req_use_carry = 1'b1;
            #1;
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'(e_d));
            chk("bp_rsp_carry", 32'(rsp_carry), 32'(e_c));
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b0; m_count++;
        chk("bp_op_count", 32'(op_count), 32'(m_count % 16));
        chk("bp_exec_valid", 32'(rsp_valid), 32'd0);
        chk("bp_alu_cin", 32'(alu_cin), 32'd1);
        @(posedge clk); #1;
        chk("bp_rsp2_valid", 32'(rsp_valid), 32'd1);
        chk("bp_rsp2_data", 32'(rsp_data), 32'h45);
        chk("bp_rsp2_carry", 32'(rsp_carry), 32'd0);
        m_carry = 1'b0;
        accept();

        // clear_carry during EXEC loses to the capture; during HOLD it applies.
        send_ref("clr_exec", ALU_OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b1);
        @(negedge clk); clear_carry = 1'b1;
        @(posedge clk); #1; clear_carry = 1'b0; m_carry = 1'b0;
        chk("clr_hold_carry_q", 32'(carry_q), 32'd0);
        chk("clr_hold_rsp_carry", 32'(rsp_carry), 32'd1);
        accept();

        // Reset while in EXEC discards the operation.
        send_ref("pre_rst", ALU_OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0);
        accept();
        @(negedge clk);
        req_valid = 1'b1; req_op = ALU_OP_ADD; req_a = 8'h01; req_b = 8'h01; req_use_carry = 1'b0;
        @(posedge clk); #1; req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_carry_q", 32'(carry_q), 32'd0);
        chk("midrst_op_count", 32'(op_count), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        m_carry = 1'b0; m_count = 0;
        @(posedge clk); #1;
        chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);

        // 2^CNT_W + 1 completions wrap the counter to 1.
        for (int i = 0; i < 17; i++) begin
            send_ref("wrap", enum_alu_opcode_t'(4'($urandom_range(0, 7))), 8'($urandom),
                     8'($urandom), 1'($urandom), 1'b0);
            accept();
        end
        chk("wrap_op_count", 32'(op_count), 32'd1);

        // Randomized traffic against the reference model.
        ph = 0; t_cin = 0; t_c = 0; t_z = 0; t_e = 0; t_a = '0; t_op = ALU_OP_ADD; t_d = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic exp_rr;
            int   r;
            @(negedge clk);
            r = $urandom_range(0, 9);
            req_op = enum_alu_opcode_t'(4'((r < 8) ? r : ((r == 8) ? 12 : 15)));
            req_a = 8'($urandom);
            req_b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            req_use_carry = 1'($urandom);
            req_valid = ($urandom_range(0, 1) == 1);
            rsp_ready = ($urandom_range(0, 1) == 1);
            clear_carry = ($urandom_range(0, 7) == 0);
            #1;
            exp_rr = (ph == 0) || ((ph == 2) && rsp_ready);
            chk("rnd_req_ready", 32'(req_ready), 32'(exp_rr));
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(ph == 2));
            chk("rnd_carry_q", 32'(carry_q), 32'(m_carry));
            chk("rnd_op_count", 32'(op_count), 32'(m_count % 16));
            if (ph == 1) begin
                chk("rnd_alu_a", 32'(alu_a), 32'(t_a));
                chk("rnd_alu_op", 32'(alu_op), 32'(t_op));
                chk("rnd_alu_cin", 32'(alu_cin), 32'(t_cin));
            end
            if (ph == 2) begin
                chk("rnd_rsp_data", 32'(rsp_data), 32'(t_d));
                chk("rnd_rsp_flags", 32'({rsp_carry, rsp_zero, rsp_err}), 32'({t_c, t_z, t_e}));
            end
            @(posedge clk);
            if (ph == 1) begin
                m_carry = t_c;
                ph = 2;
            end else begin
                logic acc;
                acc = req_valid && exp_rr;
                if ((ph == 2) && rsp_ready) begin
                    m_count++;
                    ph = 0;
                end
                if (acc) begin
                    bit upd, c, z, e;
                    t_a = req_a; t_op = req_op; t_cin = req_use_carry & m_carry;
                    ref_op(int'(req_op), int'(req_a), int'(req_b), int'(t_cin), t_d, upd, c, z, e);
                    t_c = upd ? c : (clear_carry ? 1'b0 : m_carry);
                    t_z = z; t_e = e;
                    ph = 1;
                end
                if (clear_carry) m_carry = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule
